// File: rtl/speed_switch_sequencer_if.sv
// Bus bundle for the speed switch sequencer: KEY1 IO access, STOP handshake,
// DMA status and the sequencer's status outputs.
interface speed_switch_sequencer_if;
   logic [15:0] I_IOREG_ADDR;
   logic [7:0]  I_IOREG_DATA;
   logic        I_IOREG_WE_L;
   logic        I_IOREG_RE_L;
   logic [7:0]  O_IOREG_DATA;
   logic        O_IOREG_DRIVE;
   logic        I_STOP_REQ;
   logic        O_STOP_ACK;
   logic        I_DMA_BUSY;
   logic        O_CPU_CE;
   logic        O_IS_IN_DOUBLE_SPEEDMODE;
   logic        O_DISABLE_CONTROLLER;
   logic [2:0]  O_STATE;

   modport master (
      output I_IOREG_ADDR, I_IOREG_DATA, I_IOREG_WE_L, I_IOREG_RE_L,
             I_STOP_REQ, I_DMA_BUSY,
      input  O_IOREG_DATA, O_IOREG_DRIVE, O_STOP_ACK, O_CPU_CE,
             O_IS_IN_DOUBLE_SPEEDMODE, O_DISABLE_CONTROLLER, O_STATE
   );

   modport slave (
      input  I_IOREG_ADDR, I_IOREG_DATA, I_IOREG_WE_L, I_IOREG_RE_L,
             I_STOP_REQ, I_DMA_BUSY,
      output O_IOREG_DATA, O_IOREG_DRIVE, O_STOP_ACK, O_CPU_CE,
             O_IS_IN_DOUBLE_SPEEDMODE, O_DISABLE_CONTROLLER, O_STATE
   );
endinterface

// File: rtl/speed_switch_sequencer.sv
// GBC double-speed switch sequencer: owns KEY1, drains DMA, runs the quiesce
// countdown, flips speed and derives the CPU clock enable from the 33 MHz clock.
module speed_switch_sequencer #(
   parameter int          P_DIV_SINGLE       = 8,
   parameter int          P_DIV_DOUBLE       = 4,
   parameter logic [15:0] P_COUNTDOWN_CLOCKS = 16'd255,
   parameter logic [15:0] P_KEY1_ADDR        = 16'hFF4D
) (
   input logic                      I_CLK33MHZ,
   input logic                      I_SYNC_RESET,
   speed_switch_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRAIN  = 3'd1,
      S_COUNT  = 3'd2,
      S_SWITCH = 3'd3,
      S_ACK    = 3'd4
   } state_t;

   localparam logic [7:0] C_DIV_S_M1 = 8'(P_DIV_SINGLE - 1);
   localparam logic [7:0] C_DIV_D_M1 = 8'(P_DIV_DOUBLE - 1);

   state_t      r_state;
   logic        r_speed;
   logic        r_armed;
   logic        r_stop_ack;
   logic        r_disable;
   logic [7:0]  r_cnt;
   logic [15:0] r_count;

   logic [7:0]  w_div_m1;
   logic        w_run;
   logic        w_key1_hit;
   logic        w_key1_wr;
   logic        w_cnt_wrap;
   logic [7:0]  w_cnt_next;
   logic        w_unused_data;

   assign w_div_m1      = r_speed ? C_DIV_D_M1 : C_DIV_S_M1;
   assign w_run         = (r_state == S_IDLE) || (r_state == S_ACK);
   assign w_key1_hit    = (bus.I_IOREG_ADDR == P_KEY1_ADDR);
   assign w_key1_wr     = w_key1_hit & ~bus.I_IOREG_WE_L;
   assign w_cnt_wrap    = (r_cnt == w_div_m1);
   assign w_cnt_next    = w_cnt_wrap ? 8'd0 : r_cnt + 8'd1;
   assign w_unused_data = ^bus.I_IOREG_DATA[7:1];

   // Read path is combinational so the CPU sees KEY1 in the same access cycle.
   assign bus.O_IOREG_DATA             = {r_speed, 6'b111111, r_armed};
   assign bus.O_IOREG_DRIVE            = w_key1_hit & ~bus.I_IOREG_RE_L;
   assign bus.O_CPU_CE                 = w_cnt_wrap & w_run;
   assign bus.O_STOP_ACK               = r_stop_ack;
   assign bus.O_DISABLE_CONTROLLER     = r_disable;
   assign bus.O_IS_IN_DOUBLE_SPEEDMODE = r_speed;
   assign bus.O_STATE                  = r_state;

   always_ff @(posedge I_CLK33MHZ) begin
      if (I_SYNC_RESET) begin
         r_state    <= S_IDLE;
         r_speed    <= 1'b0;
         r_armed    <= 1'b0;
         r_stop_ack <= 1'b0;
         r_disable  <= 1'b0;
         r_cnt      <= 8'd0;
         r_count    <= P_COUNTDOWN_CLOCKS;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_key1_wr)
                  r_armed <= bus.I_IOREG_DATA[0];
               // armed is the pre-edge value, so a same-cycle KEY1 write cannot start a switch
               if (bus.I_STOP_REQ && r_armed) begin
                  r_state   <= S_DRAIN;
                  r_disable <= 1'b1;
                  r_cnt     <= 8'd0;
               end else begin
                  r_cnt <= w_cnt_next;
               end
            end
            S_DRAIN: begin
               r_cnt <= 8'd0;
               if (!bus.I_DMA_BUSY) begin
                  r_state <= S_COUNT;
                  r_count <= P_COUNTDOWN_CLOCKS;
               end
            end
            S_COUNT: begin
               r_cnt <= 8'd0;
               if (r_count == 16'd0)
                  r_state <= S_SWITCH;
               else
                  r_count <= r_count - 16'd1;
            end
            S_SWITCH: begin
               // cnt is parked at 0 here, so the divisor change never shortens a period
               r_cnt      <= 8'd0;
               r_speed    <= ~r_speed;
               r_armed    <= 1'b0;
               r_disable  <= 1'b0;
               r_stop_ack <= 1'b1;
               r_state    <= S_ACK;
            end
            S_ACK: begin
               if (w_key1_wr)
                  r_armed <= bus.I_IOREG_DATA[0];
               r_cnt <= w_cnt_next;
               if (!bus.I_STOP_REQ) begin
                  r_state    <= S_IDLE;
                  r_stop_ack <= 1'b0;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_cnt      <= 8'd0;
               r_disable  <= 1'b0;
               r_stop_ack <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_speed_switch_sequencer.sv
// Bench for speed_switch_sequencer: an epoch/countdown model checked every
// cycle, plus directed scenarios with hand-computed cycle offsets.
module tb_speed_switch_sequencer;

   localparam int          DIV_S = 8;
   localparam int          DIV_D = 4;
   localparam int          CDOWN = 255;
   localparam logic [15:0] KEY1  = 16'hFF4D;

   logic clk;
   logic rst;
   int   cyc;
   int   n_vec;
   int   n_err;

   speed_switch_sequencer_if bus ();

   speed_switch_sequencer dut (
      .I_CLK33MHZ   (clk),
      .I_SYNC_RESET (rst),
      .bus          (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string nm, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  nm, act, act, exp, exp, cyc);
      end
   endfunction

   // Behavioural model: speed, armed, a run/drain/timed phase, cycles left in
   // the timed quiesce, and the cycle at which the current CE epoch began.
   bit m_on, m_speed, m_armed, m_ack, old_armed;
   int m_phase, m_left, m_epoch, div, exp_state;

   initial m_on = 1'b0;

   always @(negedge clk) begin
      if (m_on) begin
         div = m_speed ? DIV_D : DIV_S;
         chk("ce", int'(bus.O_CPU_CE),
             int'(m_phase == 0 && ((cyc - m_epoch) % div) == div - 1));
         chk("disable", int'(bus.O_DISABLE_CONTROLLER), int'(m_phase != 0));
         chk("stop_ack", int'(bus.O_STOP_ACK), int'(m_ack));
         chk("speed", int'(bus.O_IS_IN_DOUBLE_SPEEDMODE), int'(m_speed));
         exp_state = (m_phase == 1) ? 1 :
                     (m_phase == 2) ? ((m_left == 1) ? 3 : 2) :
                     (m_ack ? 4 : 0);
         chk("state", int'(bus.O_STATE), exp_state);
         chk("drive", int'(bus.O_IOREG_DRIVE),
             int'(bus.I_IOREG_ADDR == KEY1 && !bus.I_IOREG_RE_L));
         if (bus.I_IOREG_ADDR == KEY1 && !bus.I_IOREG_RE_L)
            chk("rdata", int'(bus.O_IOREG_DATA), int'({m_speed, 6'b111111, m_armed}));
      end
      if (rst) begin
         m_on    = 1'b1;
         m_speed = 1'b0;
         m_armed = 1'b0;
         m_ack   = 1'b0;
         m_phase = 0;
         m_left  = 0;
         m_epoch = cyc + 1;
      end else if (m_on) begin
         case (m_phase)
            0: begin
               old_armed = m_armed;
               if (!bus.I_IOREG_WE_L && bus.I_IOREG_ADDR == KEY1)
                  m_armed = bus.I_IOREG_DATA[0];
               if (m_ack) begin
                  if (!bus.I_STOP_REQ) m_ack = 1'b0;
               end else if (bus.I_STOP_REQ && old_armed) begin
                  m_phase = 1;
               end
            end
            1: if (!bus.I_DMA_BUSY) begin
               m_phase = 2;
               m_left  = CDOWN + 2;
            end
            default: begin
               m_left--;
               if (m_left == 0) begin
                  m_phase = 0;
                  m_ack   = 1'b1;
                  m_speed = !m_speed;
                  m_armed = 1'b0;
                  m_epoch = cyc + 1;
               end
            end
         endcase
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called in cycle 0 after reset: reset values, then CE at 7, 15, 23.
   task automatic ce_pattern(string nm);
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (i == 0) begin
            chk({nm, "_rst_state"}, int'(bus.O_STATE), 0);
            chk({nm, "_rst_speed"}, int'(bus.O_IS_IN_DOUBLE_SPEEDMODE), 0);
            chk({nm, "_rst_dis"}, int'(bus.O_DISABLE_CONTROLLER), 0);
            chk({nm, "_rst_ack"}, int'(bus.O_STOP_ACK), 0);
         end
         chk(nm, int'(bus.O_CPU_CE), int'(i == 7 || i == 15 || i == 23));
         step();
      end
   endtask

   task automatic write_key1(input logic [7:0] d);
      bus.I_IOREG_ADDR = KEY1;
      bus.I_IOREG_DATA = d;
      bus.I_IOREG_WE_L = 1'b0;
      step();
      bus.I_IOREG_WE_L = 1'b1;
   endtask

   task automatic read_key1(input logic [7:0] exp, input string nm);
      bus.I_IOREG_ADDR = KEY1;
      bus.I_IOREG_RE_L = 1'b0;
      @(negedge clk);
      chk(nm, int'(bus.O_IOREG_DATA), int'(exp));
      chk({nm, "_drive"}, int'(bus.O_IOREG_DRIVE), 1);
      step();
      bus.I_IOREG_RE_L = 1'b1;
   endtask

   // Offsets are measured from cycle N, the first cycle STOP is sampled high.
   task automatic run_switch(input int dma_cyc, output int ack_off,
                             output int ce_off, output int dis_n);
      int n;
      n       = cyc;
      ack_off = -1;
      ce_off  = -1;
      dis_n   = 0;
      bus.I_STOP_REQ = 1'b1;
      bus.I_DMA_BUSY = (dma_cyc > 0);
      step();
      for (int k = 1; k <= 320; k++) begin
         @(negedge clk);
         if (bus.O_DISABLE_CONTROLLER) dis_n++;
         if (bus.O_STOP_ACK && ack_off < 0) ack_off = k;
         if (bus.O_CPU_CE && ce_off < 0) ce_off = k;
         step();
         bus.I_DMA_BUSY = ((cyc - n) <= dma_cyc);
         if (ack_off >= 0) bus.I_STOP_REQ = 1'b0;
         if (ack_off >= 0 && k >= ack_off + 12) break;
      end
      bus.I_STOP_REQ = 1'b0;
      bus.I_DMA_BUSY = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 40000", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a, c, d, n;
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      bus.I_IOREG_ADDR = 16'h0000;
      bus.I_IOREG_DATA = 8'h00;
      bus.I_IOREG_WE_L = 1'b1;
      bus.I_IOREG_RE_L = 1'b1;
      bus.I_STOP_REQ   = 1'b0;
      bus.I_DMA_BUSY   = 1'b0;
      step();
      step();
      step();
      rst = 1'b0;
      ce_pattern("ce_boot");
      read_key1(8'h7E, "key1_boot");

      bus.I_IOREG_ADDR = 16'hFF4C;
      bus.I_IOREG_RE_L = 1'b0;
      @(negedge clk);
      chk("drive_other_addr", int'(bus.O_IOREG_DRIVE), 0);
      step();
      bus.I_IOREG_RE_L = 1'b1;

      // STOP while unarmed: nothing happens
      bus.I_STOP_REQ = 1'b1;
      repeat (20) step();
      @(negedge clk);
      chk("unarmed_state", int'(bus.O_STATE), 0);
      chk("unarmed_ack", int'(bus.O_STOP_ACK), 0);
      step();
      bus.I_STOP_REQ = 1'b0;

      // Switch to double speed, DMA idle
      write_key1(8'h01);
      read_key1(8'h7F, "key1_armed");
      run_switch(0, a, c, d);
      chk("up_ack_offset", a, 259);
      chk("up_first_ce", c, 262);
      chk("up_disable_len", d, 258);
      read_key1(8'hFE, "key1_double");

      // Switch back with DMA busy for 10 cycles
      write_key1(8'h01);
      run_switch(10, a, c, d);
      chk("down_ack_offset", a, 269);
      chk("down_first_ce", c, 276);
      chk("down_disable_len", d, 268);
      read_key1(8'h7E, "key1_single");

      // Up again, then reset in the middle of the countdown
      write_key1(8'h01);
      run_switch(0, a, c, d);
      chk("up2_ack_offset", a, 259);
      write_key1(8'h01);
      n = cyc;
      bus.I_STOP_REQ = 1'b1;
      repeat (40) step();
      @(negedge clk);
      chk("mid_count_state", int'(bus.O_STATE), 2);
      chk("mid_count_dis", int'(bus.O_DISABLE_CONTROLLER), 1);
      chk("mid_count_speed", int'(bus.O_IS_IN_DOUBLE_SPEEDMODE), 1);
      step();
      repeat (50 - (cyc - n)) step();
      rst = 1'b1;
      bus.I_STOP_REQ = 1'b0;
      step();
      rst = 1'b0;
      ce_pattern("ce_after_rst");
      read_key1(8'h7E, "key1_after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/speed_switch_sequencer.md
# speed_switch_sequencer

Sequences the GBC CPU double-speed switch and generates the main-domain clock enable from the single 33 MHz clock, so the fabric runs on one clock with no muxed clocks. Owns the KEY1 register (arm bit and current-speed bit) and handshakes with the CPU's STOP request. Waits for DMA to go idle, holds the controller disabled for a fixed countdown, then toggles speed and releases the CPU. Sits between the CPU core, the IO register bus and the DMA engine.

## Interface
- P_DIV_SINGLE, 8: 33 MHz cycles per CPU enable pulse in normal speed; legal range 2..256.
- P_DIV_DOUBLE, 4: 33 MHz cycles per CPU enable pulse in double speed; legal range 2..256.
- P_COUNTDOWN_CLOCKS, 255: quiesce countdown load value, 16 bits.
- P_KEY1_ADDR, 16'hFF4D: KEY1 register address.
- I_CLK33MHZ  in  1  system clock; all logic is on its rising edge.
- I_SYNC_RESET  in  1  synchronous, active-high reset.
- I_IOREG_ADDR  in  16  IO register address.
- I_IOREG_DATA  in  8  IO write data.
- I_IOREG_WE_L  in  1  IO write strobe, active low.
- I_IOREG_RE_L  in  1  IO read strobe, active low.
- O_IOREG_DATA  out  8  KEY1 read data.
- O_IOREG_DRIVE  out  1  high when this block drives the read bus.
- I_STOP_REQ  in  1  CPU has executed STOP; level, held until O_STOP_ACK is seen.
- O_STOP_ACK  out  1  switch complete; held until I_STOP_REQ drops.
- I_DMA_BUSY  in  1  DMA/HDMA transfer in progress.
- O_CPU_CE  out  1  one-cycle CPU/IO clock-enable pulse.
- O_IS_IN_DOUBLE_SPEEDMODE  out  1  current speed: 1 = double.
- O_DISABLE_CONTROLLER  out  1  holds memory controller and peripherals off during the switch.
- O_STATE  out  3  FSM state, for debug.

## Operation
- KEY1 register:
  - A write occurs on any cycle with I_IOREG_WE_L=0 and address = P_KEY1_ADDR. In IDLE or ACK, the write sets armed <= I_IOREG_DATA[0].
  - Writes in DRAIN, COUNT or SWITCH are ignored.
  - Read data is {speed, 6'b111111, armed}. O_IOREG_DRIVE = address match & ~I_IOREG_RE_L, decoded combinationally.
- Enable generator:
  - An 8-bit counter cnt runs from 0 to div-1 and then wraps to 0. div = speed ? P_DIV_DOUBLE : P_DIV_SINGLE.
  - O_CPU_CE = (cnt == div-1) & run, where run = state is IDLE or ACK.
  - The counter is held at 0 in DRAIN, COUNT and SWITCH.
- FSM states: IDLE=0, DRAIN=1, COUNT=2, SWITCH=3, ACK=4.
  - IDLE: I_STOP_REQ & armed -> DRAIN. I_STOP_REQ & ~armed -> stay in IDLE with no ack; ordinary STOP wake is handled elsewhere.
  - DRAIN: O_DISABLE_CONTROLLER=1. Leaves for COUNT in the first cycle I_DMA_BUSY=0, loading count <= P_COUNTDOWN_CLOCKS.
  - COUNT: O_DISABLE_CONTROLLER=1. count decrements each cycle. count==0 -> SWITCH.
  - SWITCH: one cycle. O_DISABLE_CONTROLLER=1. On exit: speed <= ~speed, armed <= 0 -> ACK.
  - ACK: O_STOP_ACK=1, O_DISABLE_CONTROLLER=0, enables run at the new rate. ~I_STOP_REQ -> IDLE.
- All outputs except the two IO read outputs are registered or decoded from registered state.
- Reset values: state=IDLE, speed=0, armed=0, cnt=0, count=P_COUNTDOWN_CLOCKS, O_STOP_ACK=0, O_DISABLE_CONTROLLER=0, O_CPU_CE=0.
- Reset takes effect on any cycle, including mid-switch. After reset the block runs at single speed and no switch is pending.

## Timing
- Cycle 0 is the first cycle after reset deasserts. The first O_CPU_CE is in cycle P_DIV_SINGLE-1; further pulses follow every P_DIV_SINGLE cycles.
- Switch timing, with I_STOP_REQ first sampled high in cycle N, armed=1, DMA idle:
  - DRAIN in N+1.
  - COUNT in N+2 .. N+2+P_COUNTDOWN_CLOCKS, which is 256 cycles at the default.
  - SWITCH in N+258 (default).
  - ACK and new speed visible in N+259.
  - First new-rate O_CPU_CE in N+259+div_new-1.
- Each cycle of I_DMA_BUSY=1 in DRAIN extends the sequence by one cycle.
- No enable pulse from cycle N+1 until ACK. An O_CPU_CE pulse in cycle N is still delivered.
- The period is never shortened: the divisor changes only while cnt is held at 0.
- Simultaneous STOP_REQ and KEY1 write in IDLE: the FSM uses armed as registered before that edge.

## Test plan
- Reset then idle, defaults: O_CPU_CE pulses in cycles 7, 15, 23. A KEY1 read returns 8'h7E.
- Write KEY1=8'h01, then hold I_STOP_REQ with DMA idle: O_DISABLE_CONTROLLER is high for 258 cycles; O_STOP_ACK and speed=1 appear in N+259; the CE period becomes 4; a KEY1 read returns 8'hFE.
- Same switch with I_DMA_BUSY held for 10 cycles after the request: ACK arrives in N+269, and no O_CPU_CE pulse occurs in between.
- STOP with armed=0: no state change, O_STOP_ACK stays 0, CE continues unchanged.
- Assert I_SYNC_RESET during COUNT after double speed is set: state returns to IDLE, speed=0, disable=0, CE period 8.
- Run a second switch back from double speed: speed returns to 0 and the CE period returns to 8.
